// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

  // Loader sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_FIN    = 2'd3
  } ccff_state_t;

  // CRC-8 generator polynomial x^8 + x^2 + x + 1.
  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One bit-serial CRC-8 step, MSB-first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

  // Number of bitstream words needed to fill the chain.
  function automatic int ccff_num_words(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Number of useful (upper) bits carried by the final word.
  function automatic int ccff_last_bits(input int chain_len, input int word_w);
    return chain_len - (ccff_num_words(chain_len, word_w) - 1) * word_w;
  endfunction

endpackage

// File: rtl/ccff_crc8_serial.sv
// Bit-serial CRC-8 accumulator with synchronous clear and enable.
module ccff_crc8_serial
  import ccff_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       bit_in,
  output logic [7:0] crc
);

  // Clear has priority so a new operation always starts from 0x00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words MSB-first into a configuration flip-flop chain,
// then optionally rotates the chain once to CRC-check it without disturbing it.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8,
  parameter int VERIFY_EN = 1
) (
  input  logic              pReset,
  input  logic              prog_clk,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int NUM_WORDS = ccff_num_words(CHAIN_LEN, WORD_W);
  localparam int LAST_BITS = ccff_last_bits(CHAIN_LEN, WORD_W);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W = $clog2(NUM_WORDS + 1);
  localparam int SH_W   = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WCNT_W-1:0] NW        = WCNT_W'(NUM_WORDS);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);
  localparam logic [SH_W-1:0]   FULL_SH   = SH_W'(WORD_W);
  localparam logic [SH_W-1:0]   LAST_SH   = SH_W'(LAST_BITS);
  localparam logic [SH_W-1:0]   ONE_SH    = SH_W'(1);

  ccff_state_t        state_reg;
  logic [WORD_W-1:0]  sh_reg;
  logic [SH_W-1:0]    sh_cnt_reg;
  logic [WCNT_W-1:0]  word_cnt_reg;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic               done_reg;
  logic               error_reg;

  logic [7:0]         crc_load;
  logic [7:0]         crc_chk;
  logic               shift_load;
  logic               in_verify;
  logic               handshake;
  logic               op_start;

  // Decode of the registered state; only the verify passthrough is combinational.
  assign in_verify     = (state_reg == ST_VERIFY);
  assign shift_load    = (state_reg == ST_LOAD) && (sh_cnt_reg != '0);
  assign op_start      = (state_reg == ST_IDLE) && start;
  // A new word may land while the last bit of the previous one shifts out,
  // which keeps the chain fed at one bit per cycle.
  assign word_ready    = (state_reg == ST_LOAD) && (word_cnt_reg < NW) &&
                         (sh_cnt_reg <= ONE_SH);
  assign handshake     = word_valid && word_ready;
  assign ccff_shift_en = shift_load || in_verify;
  assign ccff_head     = in_verify ? ccff_tail : (shift_load & sh_reg[WORD_W-1]);
  assign busy          = (state_reg == ST_LOAD) || in_verify;
  assign done          = done_reg;
  assign error         = error_reg;

  // Sequencer: word intake, bit shifting, verify rotation and result capture.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_reg    <= ST_IDLE;
      sh_reg       <= '0;
      sh_cnt_reg   <= '0;
      word_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg    <= ST_LOAD;
            sh_cnt_reg   <= '0;
            word_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (shift_load) begin
            sh_reg      <= sh_reg << 1;
            sh_cnt_reg  <= sh_cnt_reg - ONE_SH;
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          end
          // A handshake overrides the shift update; the final word keeps
          // only its upper bits because fewer shifts are scheduled for it.
          if (handshake) begin
            sh_reg       <= word_data;
            sh_cnt_reg   <= (word_cnt_reg == LAST_WORD) ? LAST_SH : FULL_SH;
            word_cnt_reg <= word_cnt_reg + WCNT_W'(1);
          end
          if (shift_load && (bit_cnt_reg == LAST_IDX)) begin
            state_reg   <= (VERIFY_EN != 0) ? ST_VERIFY : ST_FIN;
            bit_cnt_reg <= '0;
          end
        end

        ST_VERIFY: begin
          // Exactly CHAIN_LEN rotations return every bit to its slot.
          bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          if (bit_cnt_reg == LAST_IDX) begin
            state_reg <= ST_FIN;
          end
        end

        ST_FIN: begin
          done_reg  <= 1'b1;
          error_reg <= (VERIFY_EN != 0) && (crc_chk != crc_load);
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // CRC of the bits as they were written into the head.
  ccff_crc8_serial u_crc_load (
    .clk    (prog_clk),
    .rst    (pReset),
    .en     (shift_load),
    .clr    (op_start),
    .bit_in (sh_reg[WORD_W-1]),
    .crc    (crc_load)
  );

  // CRC of the bits as they come back out of the tail during rotation.
  ccff_crc8_serial u_crc_chk (
    .clk    (prog_clk),
    .rst    (pReset),
    .en     (in_verify),
    .clr    (op_start),
    .bit_in (ccff_tail),
    .crc    (crc_chk)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: two loaders (16-bit and 12-bit chains) driving behavioural chains.
module tb_ccff_chain_loader;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;

  always #5 prog_clk = ~prog_clk;

  // 16-bit chain instance
  logic       start16 = 1'b0, wv16 = 1'b0, wr16, head16, sh16, tail16, busy16, done16, err16;
  logic [7:0] wd16 = 8'h00;
  logic [15:0] chain16 = 16'h0000;
  logic        flip16  = 1'b0;
  logic [15:0] c16;

  // 12-bit chain instance
  logic       start12 = 1'b0, wv12 = 1'b0, wr12, head12, sh12, tail12, busy12, done12, err12;
  logic [7:0] wd12 = 8'h00;
  logic [11:0] chain12 = 12'h000;

  int checks   = 0;
  int failures = 0;
  int hs16_cnt = 0, stall16_cnt = 0, hs12_cnt = 0;

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .VERIFY_EN(1)) dut16 (
    .pReset(pReset), .prog_clk(prog_clk), .start(start16), .word_valid(wv16),
    .word_data(wd16), .word_ready(wr16), .ccff_head(head16), .ccff_shift_en(sh16),
    .ccff_tail(tail16), .busy(busy16), .done(done16), .error(err16)
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .VERIFY_EN(1)) dut12 (
    .pReset(pReset), .prog_clk(prog_clk), .start(start12), .word_valid(wv12),
    .word_data(wd12), .word_ready(wr12), .ccff_head(head12), .ccff_shift_en(sh12),
    .ccff_tail(tail12), .busy(busy12), .done(done12), .error(err12)
  );

  // Behavioural chains: bit 0 is the head end, the top bit is the tail end.
  // flip16 corrupts bit 5 on the edge it is sampled, before that edge's shift.
  assign tail16 = chain16[15];
  assign tail12 = chain12[11];
  assign c16    = chain16 ^ {10'd0, flip16, 5'd0};

  always @(posedge prog_clk) begin
    if (sh16) chain16 <= {c16[14:0], head16};
    else      chain16 <= c16;
    if (sh12) chain12 <= {chain12[10:0], head12};
  end

  // Handshake and stall counters (stall = busy cycle without a chain shift).
  always @(posedge prog_clk) begin
    if (wv16 && wr16)    hs16_cnt    <= hs16_cnt + 1;
    if (busy16 && !sh16) stall16_cnt <= stall16_cnt + 1;
    if (wv12 && wr12)    hs12_cnt    <= hs12_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One load of 0xA5,0x3C into the 16-bit chain. N0 is the negedge where start
  // is raised (sampled at edge t); N(k) is the negedge after edge t+k-1.
  // With no gap the load ends after edge t+17 and done rises at edge t+34.
  task automatic run16(input string name, input int gap, input bit extra_start,
                       input bit inject, input logic exp_err);
    int hs0, st0;
    hs0 = hs16_cnt;
    st0 = stall16_cnt;
    @(negedge prog_clk);
    start16 = 1'b1; wv16 = 1'b1; wd16 = 8'hA5;
    @(negedge prog_clk);
    start16 = 1'b0;
    chk({name, "_busy"},  busy16, 1);
    chk({name, "_doneclr"}, done16, 0);
    chk({name, "_ready"}, wr16, 1);
    for (int n = 2; n <= 35 + gap; n++) begin
      @(negedge prog_clk);
      if (n == 2) begin
        wd16 = 8'h3C;
        if (gap > 0) wv16 = 1'b0;
      end
      if (gap > 0 && n == 9 + gap) wv16 = 1'b1;
      start16 = extra_start && (n == 5);
      flip16  = inject && (n == 18);
      if (gap > 0 && n == 11) chk({name, "_bubble"}, sh16, 0);
      if (!inject && n == 18 + gap) chk({name, "_loaded"}, chain16, 16'hA53C);
      if (n == 34 + gap) chk({name, "_notdone"}, done16, 0);
    end
    chk({name, "_done"},  done16, 1);
    chk({name, "_error"}, err16, exp_err);
    chk({name, "_hs"},    hs16_cnt - hs0, 2);
    // One stall before the first handshake, plus the deliberate bubbles.
    chk({name, "_stall"}, stall16_cnt - st0, 1 + gap);
    if (!inject) chk({name, "_kept"}, chain16, 16'hA53C);
    wv16 = 1'b0;
    $display("txn %s: chain=%h done=%0b error=%0b", name, chain16, done16, err16);
  endtask

  initial begin
    int hs0;
    // Reset state
    repeat (3) @(negedge prog_clk);
    chk("rst_ready", wr16, 0);
    chk("rst_head",  head16, 0);
    chk("rst_shift", sh16, 0);
    chk("rst_busy",  busy16, 0);
    chk("rst_done",  done16, 0);
    chk("rst_error", err16, 0);
    chk("rst_busy12", busy12, 0);
    pReset = 1'b0;
    @(negedge prog_clk);
    chk("idle_ready", wr16, 0);

    // Basic load with verify
    run16("basic", 0, 1'b0, 1'b0, 1'b0);
    chk("basic_held", done16, 1);

    // Partial last word on the 12-bit chain: 0xF0 then upper nibble of 0xAB
    hs0 = hs12_cnt;
    @(negedge prog_clk);
    start12 = 1'b1; wv12 = 1'b1; wd12 = 8'hF0;
    @(negedge prog_clk);
    start12 = 1'b0;
    chk("part_busy", busy12, 1);
    @(negedge prog_clk);
    wd12 = 8'hAB;
    repeat (12) @(negedge prog_clk);
    chk("part_loaded", chain12, 12'hF0A);
    repeat (12) @(negedge prog_clk);
    chk("part_notdone", done12, 0);
    @(negedge prog_clk);
    chk("part_done",  done12, 1);
    chk("part_error", err12, 0);
    chk("part_hs",    hs12_cnt - hs0, 2);
    chk("part_kept",  chain12, 12'hF0A);
    wv12 = 1'b0;
    $display("txn partial: chain=%h done=%0b error=%0b", chain12, done12, err12);

    // Backpressure: three empty cycles between the words
    run16("bp", 3, 1'b0, 1'b0, 1'b0);

    // Error injection during the first verify cycle
    run16("inject", 0, 1'b0, 1'b1, 1'b1);

    // Reset in the 6th load cycle (negedge N6)
    @(negedge prog_clk);
    start16 = 1'b1; wv16 = 1'b1; wd16 = 8'hA5;
    @(negedge prog_clk);
    start16 = 1'b0;
    @(negedge prog_clk);
    wd16 = 8'h3C;
    repeat (4) @(negedge prog_clk);
    chk("abort_shifting", sh16, 1);
    pReset = 1'b1;
    @(negedge prog_clk);
    chk("abort_busy",  busy16, 0);
    chk("abort_ready", wr16, 0);
    chk("abort_head",  head16, 0);
    chk("abort_shift", sh16, 0);
    chk("abort_done",  done16, 0);
    chk("abort_error", err16, 0);
    pReset = 1'b0;
    wv16   = 1'b0;
    @(negedge prog_clk);
    chk("abort_idle", busy16, 0);
    $display("txn abort: busy=%0b done=%0b", busy16, done16);
    run16("fresh", 0, 1'b0, 1'b0, 1'b0);

    // Start pulse during LOAD is ignored
    run16("startbusy", 0, 1'b1, 1'b0, 1'b0);
    @(negedge prog_clk);
    chk("startbusy_idle", busy16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
